mem_march_bist: RTL
===================

# mem_march_bist

Parametrised on-chip register-file memory with a built-in March C- self-test engine, a direct host read/write port and fault injection. It is the next-generation memory test block for the Tiny Tapeout memory experiments. It sits directly under the `tt_um_*` top, wired to `ui_in`/`uio_in`/`uo_out`. Between self-tests, the memory is accessed directly. A single `start` pulse runs a full march over every address and reports a pass/fail summary.

## Interface
Parameters:
- `ADDR_BITS`, default 5: address width. Depth is N = 2^ADDR_BITS.
- `DATA_BITS`, default 8: word width.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: launches the BIST when sampled high while idle.
- `we`, input, 1: direct write enable. Ignored while busy.
- `addr`, input, ADDR_BITS: direct address. Also serves as the injection target address.
- `wdata`, input, DATA_BITS: direct write data.
- `inject`, input, 1: fault-injection enable.
- `rdata`, output, DATA_BITS: registered read data.
- `busy`, output, 1: BIST running.
- `done`, output, 1: sticky. Last BIST completed.
- `fail`, output, 1: sticky. Last BIST saw at least one mismatch.
- `err_count`, output, 8: mismatch count, saturating at 255.
- `fail_addr`, output, ADDR_BITS: address of the first mismatch.
- `fail_syn`, output, DATA_BITS: XOR of read data and expected data at the first mismatch.

## Operation
- Storage is an N×DATA_BITS register array. Contents are not reset.
- States:
  - IDLE: direct access.
  - RUN: march in progress.
  - IDLE→RUN: `start`=1 in IDLE.
  - RUN→IDLE: after the last compare, or on reset.
- Direct access in IDLE:
  - `we`=1 writes `wdata` to `mem[addr]`.
  - Every cycle, `rdata` is loaded with `mem[addr]`. If `we` is also 1, `rdata` gets the old contents (read-before-write).
- Precedence: `start` and `we` high together in IDLE: `start` wins and the write is dropped.
- March C- elements run in this order. A = ascending (0..N-1), D = descending (N-1..0).
  - E0 A: w0
  - E1 A: r0, w1
  - E2 A: r1, w0
  - E3 D: r0, w1
  - E4 D: r1, w0
  - E5 A: r0
- Data patterns: "0" is all-zeros and "1" is all-ones.
- Cycle cost per address:
  - E0: one cycle, a write.
  - E1–E5: two cycles.
  - Phase R: the address is driven and `rdata` is registered from memory.
  - Phase C: `rdata` is compared with the expected pattern. In E1–E4 the new pattern is written in the same cycle.
- While busy, `rdata` shows the BIST read register.
- On a mismatch in phase C:
  - `err_count` increments, saturating at 255.
  - If it is the first mismatch of this run, `fail_addr` and `fail_syn` are captured and `fail` is set.
- Fault injection: any BIST write to an address equal to the live `addr` input, with `inject`=1, has bit 0 forced to 1 (stuck-at-1 model). Injection does not affect direct writes.
- On an accepted `start`:
  - `done`, `fail`, `err_count`, `fail_addr` and `fail_syn` are cleared.
  - The results then hold until the next accepted `start`.
- `start` during RUN is ignored.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `fail`=0.
  - `err_count`=0, `fail_addr`=0, `fail_syn`=0, `rdata`=0.
  - State is IDLE.
- Start: if `start` is sampled at edge T, then `busy`=1 from T+1.
- Run length: `busy` is high for exactly 11·N cycles (N for E0, plus 5·2N for E1–E5). For N=32 this is 352 cycles.
- End of run:
  - The final E5 compare of address 0... (ascending, so address N-1) happens in the last busy cycle.
  - On the following edge: `busy`=0, `done`=1, and `fail`/`err_count` are final.
  - In that same cycle the block is back in IDLE, so a new `start` is accepted there.
- Direct read latency is 1 cycle: `addr` at edge T gives `rdata` valid after T.
- Reset mid-run:
  - Takes effect at the next edge: IDLE, all outputs at reset values.
  - Memory contents are whatever the march left.
- End state: after a clean run, every word is all-zeros (E4 writes 0 last).

## Test plan
- Direct access: write 0xA5 to addr 3, then 0x3C to addr 31; read both → `rdata`=0xA5 and 0x3C, each one cycle after the address.
- Clean BIST (defaults):
  - Pulse `start` → `busy` high for exactly 352 cycles, then `done`=1, `fail`=0, `err_count`=0.
  - Afterwards every address reads 0x00.
- Injection: `addr`=5, `inject`=1, pulse `start`.
  - Failures occur in E1, E3 and E5, so `err_count`=3, `fail`=1, `fail_addr`=5, `fail_syn`=0x01.
- `we`=1 with `wdata`=0xFF at addr 7 during RUN, and a second `start` mid-run:
  - Both are ignored.
  - `busy` length is still 352 cycles.
  - addr 7 reads 0x00 after the run.
- `rst_n`=0 for one cycle at busy cycle 100 → next cycle `busy`=0, `done`=0, `err_count`=0. A fresh `start` then completes a clean run.
- Results hold: after the injected run, toggle `inject` and `addr` in IDLE → `err_count`, `fail_addr` and `fail_syn` are unchanged until the next `start`, which clears them.

Source files
------------

// File: rtl/mem_march_bist_if.sv
// Host-side bundle for mem_march_bist: direct access, BIST control and result readback.
interface mem_march_bist_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic                 inject;
  logic [DATA_BITS-1:0] rdata;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [7:0]           err_count;
  logic [ADDR_BITS-1:0] fail_addr;
  logic [DATA_BITS-1:0] fail_syn;

  modport master (
    output start, we, addr, wdata, inject,
    input  rdata, busy, done, fail, err_count, fail_addr, fail_syn
  );

  modport slave (
    input  start, we, addr, wdata, inject,
    output rdata, busy, done, fail, err_count, fail_addr, fail_syn
  );
endinterface

// File: rtl/mem_march_bist.sv
// Register-file memory with a March C- self-test engine, direct host port and
// stuck-at-1 fault injection on BIST writes to the live host address.
module mem_march_bist #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_march_bist_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               state_next;

  logic [2:0]           elem;
  logic                 phase_c;
  logic [ADDR_BITS-1:0] bist_addr;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  logic                 done_q;
  logic                 fail_q;
  logic [7:0]           err_q;
  logic [ADDR_BITS-1:0] fail_addr_q;
  logic [DATA_BITS-1:0] fail_syn_q;

  logic                 busy;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 bist_read;
  logic                 compare_en;

  logic                 accept;
  logic                 descending;
  logic                 at_end;
  logic                 last_step;
  logic                 write_ones;
  logic                 expect_ones;
  logic [DATA_BITS-1:0] expect_word;
  logic                 mismatch;

  assign accept      = (state == IDLE) && bus.start;
  assign descending  = (elem == 3'd3) || (elem == 3'd4);
  assign at_end      = descending ? (bist_addr == '0) : (bist_addr == ADDR_MAX);
  assign last_step   = (state == RUN) && (elem == 3'd5) && phase_c && at_end;
  assign write_ones  = (elem == 3'd1) || (elem == 3'd3);
  assign expect_ones = (elem == 3'd2) || (elem == 3'd4);
  assign expect_word = expect_ones ? {DATA_BITS{1'b1}} : {DATA_BITS{1'b0}};
  assign mismatch    = compare_en && (rdata_q != expect_word);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // E0 is a single write per address; E1-E5 split into a read phase and a compare(+write) phase.
  always_comb begin
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = bus.addr;
    mem_wdata  = bus.wdata;
    bist_read  = 1'b0;
    compare_en = 1'b0;
    case (state)
      IDLE: begin
        mem_we = bus.we && !bus.start;
      end
      RUN: begin
        busy      = 1'b1;
        mem_waddr = bist_addr;
        mem_wdata = write_ones ? {DATA_BITS{1'b1}} : {DATA_BITS{1'b0}};
        if (bus.inject && (bist_addr == bus.addr)) mem_wdata[0] = 1'b1;
        if (elem == 3'd0) begin
          mem_we = 1'b1;
        end else if (!phase_c) begin
          bist_read = 1'b1;
        end else begin
          compare_en = 1'b1;
          mem_we     = (elem != 3'd5);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      elem      <= 3'd0;
      phase_c   <= 1'b0;
      bist_addr <= '0;
    end else if (state == RUN) begin
      if (elem == 3'd0) begin
        if (bist_addr == ADDR_MAX) begin
          elem      <= 3'd1;
          bist_addr <= '0;
        end else begin
          bist_addr <= bist_addr + 1'b1;
        end
      end else if (!phase_c) begin
        phase_c <= 1'b1;
      end else begin
        phase_c <= 1'b0;
        if (at_end) begin
          elem      <= elem + 3'd1;
          bist_addr <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
        end else if (descending) begin
          bist_addr <= bist_addr - 1'b1;
        end else begin
          bist_addr <= bist_addr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read register is shared: host reads in IDLE, march reads during the R phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state == IDLE) begin
      rdata_q <= mem[bus.addr];
    end else if (bist_read) begin
      rdata_q <= mem[bist_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= '0;
      fail_syn_q  <= '0;
    end else begin
      if (last_step) done_q <= 1'b1;
      if (mismatch) begin
        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
        if (!fail_q) begin
          fail_q      <= 1'b1;
          fail_addr_q <= bist_addr;
          fail_syn_q  <= rdata_q ^ expect_word;
        end
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.err_count = err_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_syn  = fail_syn_q;

endmodule
